// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause
// bit positions and the EPC selection rule.
package cp0_exception_unit_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_IP2_BIT  = 10;
  localparam int CAUSE_BD_BIT   = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_0003;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0400;

  typedef enum logic {
    ST_NORMAL     = 1'b0,
    ST_IN_HANDLER = 1'b1
  } cp0_state_e;

  // Delay-slot instructions restart at the branch; SYSCALL resumes after itself.
  function automatic logic [31:0] calc_epc(input logic [31:0] pc,
                                           input logic        in_delay_slot,
                                           input logic        is_syscall);
    if (in_delay_slot) begin
      return pc - 32'd4;
    end else if (is_syscall) begin
      return pc + 32'd4;
    end else begin
      return pc;
    end
  endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// MTC0/MFC0 access bus between the pipeline and the CP0 exception unit.
interface cp0_exception_unit_if;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;

  modport master (output cp0_we, output cp0_addr, output cp0_wdata, input cp0_rdata);
  modport slave  (input cp0_we, input cp0_addr, input cp0_wdata, output cp0_rdata);
endinterface

// File: rtl/cp0_exception_unit_regfile.sv
// Status/Cause/EPC storage with MTC0 write masking and the MFC0 read mux.
module cp0_exception_unit_regfile
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] STATUS_RESET = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        exc_take_i,
  input  logic [4:0]  exc_code_i,
  input  logic        exc_first_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_epc_i,
  input  logic        eret_take_i,
  input  logic        int_set_i,
  input  logic        int_taken_i,
  output logic        status_ie_o,
  output logic        status_exl_o,
  output logic        int_pending_o,
  output logic [31:0] epc_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  // Next-state for all CP0 registers; the top guarantees MTC0 and events never coincide.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (wr_en_i) begin
      case (addr_i)
        CP0_REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        CP0_REG_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
        CP0_REG_EPC:    epc_d    = wdata_i;
        default:        ;
      endcase
    end else if (exc_take_i) begin
      status_d[STATUS_EXL_BIT] = 1'b1;
      cause_d[6:2]             = exc_code_i;
      if (exc_first_i) begin
        cause_d[CAUSE_BD_BIT] = exc_bd_i;
        epc_d                 = exc_epc_i;
      end else begin
        epc_d = epc_q;
      end
    end else if (eret_take_i) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end else begin
      status_d = status_q;
    end
    if (int_taken_i) begin
      cause_d[CAUSE_IP2_BIT] = 1'b0;
    end else begin
      cause_d[CAUSE_IP2_BIT] = cause_d[CAUSE_IP2_BIT];
    end
    // A new edge wins over any clear in the same cycle.
    if (int_set_i) begin
      cause_d[CAUSE_IP2_BIT] = 1'b1;
    end else begin
      cause_d[CAUSE_IP2_BIT] = cause_d[CAUSE_IP2_BIT];
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= 32'h0000_0000;
      epc_q    <= 32'h0000_0000;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // MFC0 read mux; returns pre-edge values.
  always_comb begin
    case (addr_i)
      CP0_REG_STATUS: rdata_o = status_q;
      CP0_REG_CAUSE:  rdata_o = cause_q;
      CP0_REG_EPC:    rdata_o = epc_q;
      default:        rdata_o = 32'h0000_0000;
    endcase
  end

  assign status_ie_o   = status_q[STATUS_IE_BIT];
  assign status_exl_o  = status_q[STATUS_EXL_BIT];
  assign int_pending_o = cause_q[CAUSE_IP2_BIT];
  assign epc_o         = epc_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception controller: event priority, EPC selection, handler state and
// the IF redirect/flush for SYSCALL, reserved instruction, interrupt and ERET.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 id_valid,
  input  logic [31:0]          id_pc,
  input  logic                 id_inDelaySlot,
  input  logic                 exc_syscall,
  input  logic                 exc_illegal,
  input  logic                 exc_eret,
  input  logic                 ext_int,
  cp0_exception_unit_if.slave  cp0_bus,
  output logic                 epc_ctrl,
  output logic [31:0]          jumpAddressExcept,
  output logic                 flush_if_id,
  output logic                 in_handler
);

  cp0_state_e  state_q, state_d;
  logic        ext_int_q;
  logic        status_ie, status_exl, int_pending;
  logic [31:0] epc_val;
  logic        gate, take_eret, take_ill, take_sys, take_int, take_exc;
  logic        mtc0_en, mtc0_status, int_set;
  logic [4:0]  exc_code;
  logic [31:0] epc_new;

  assign gate      = id_valid & ~stall;
  assign take_eret = gate & exc_eret;
  assign take_ill  = gate & ~exc_eret & exc_illegal;
  assign take_sys  = gate & ~exc_eret & ~exc_illegal & exc_syscall;
  assign take_int  = gate & ~exc_eret & ~exc_illegal & ~exc_syscall
                   & int_pending & status_ie & ~status_exl;
  assign take_exc  = take_ill | take_sys | take_int;

  // An MTC0 that coincides with any redirect is dropped.
  assign mtc0_en     = cp0_bus.cp0_we & gate & ~(take_eret | take_exc);
  assign mtc0_status = mtc0_en & (cp0_bus.cp0_addr == CP0_REG_STATUS);
  // Interrupt edges are latched even while the pipeline is gated.
  assign int_set     = ext_int & ~ext_int_q;
  assign epc_new     = calc_epc(id_pc, id_inDelaySlot, take_sys);

  // Exception code of the winning synchronous/asynchronous event.
  always_comb begin
    exc_code = EXC_INT;
    if (take_ill) begin
      exc_code = EXC_RI;
    end else if (take_sys) begin
      exc_code = EXC_SYS;
    end else begin
      exc_code = EXC_INT;
    end
  end

  // Handler state; MTC0 writes to EXL keep it aligned with Status.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (take_exc) begin
          state_d = ST_IN_HANDLER;
        end else if (mtc0_status && cp0_bus.cp0_wdata[STATUS_EXL_BIT]) begin
          state_d = ST_IN_HANDLER;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_IN_HANDLER: begin
        if (take_eret) begin
          state_d = ST_NORMAL;
        end else if (mtc0_status && !cp0_bus.cp0_wdata[STATUS_EXL_BIT]) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_IN_HANDLER;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // State register and interrupt edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_NORMAL;
      ext_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_int_q <= ext_int;
    end
  end

  cp0_exception_unit_regfile #(
    .STATUS_RESET (STATUS_RESET)
  ) u_regfile (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (mtc0_en),
    .addr_i        (cp0_bus.cp0_addr),
    .wdata_i       (cp0_bus.cp0_wdata),
    .rdata_o       (cp0_bus.cp0_rdata),
    .exc_take_i    (take_exc),
    .exc_code_i    (exc_code),
    .exc_first_i   (~status_exl),
    .exc_bd_i      (id_inDelaySlot),
    .exc_epc_i     (epc_new),
    .eret_take_i   (take_eret),
    .int_set_i     (int_set),
    .int_taken_i   (take_int),
    .status_ie_o   (status_ie),
    .status_exl_o  (status_exl),
    .int_pending_o (int_pending),
    .epc_o         (epc_val)
  );

  assign epc_ctrl          = take_eret | take_exc;
  assign flush_if_id       = epc_ctrl;
  assign jumpAddressExcept = take_eret ? epc_val : HANDLER_ADDR;
  assign in_handler        = (state_q == ST_IN_HANDLER);

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit.
module tb_cp0_exception_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_inDelaySlot;
  logic        exc_syscall;
  logic        exc_illegal;
  logic        exc_eret;
  logic        ext_int;
  logic        epc_ctrl;
  logic [31:0] jumpAddressExcept;
  logic        flush_if_id;
  logic        in_handler;

  int tests_run;
  int tests_failed;

  cp0_exception_unit_if bus ();

  cp0_exception_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_inDelaySlot    (id_inDelaySlot),
    .exc_syscall       (exc_syscall),
    .exc_illegal       (exc_illegal),
    .exc_eret          (exc_eret),
    .ext_int           (ext_int),
    .cp0_bus           (bus),
    .epc_ctrl          (epc_ctrl),
    .jumpAddressExcept (jumpAddressExcept),
    .flush_if_id       (flush_if_id),
    .in_handler        (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    stall          = 1'b0;
    id_valid       = 1'b0;
    id_pc          = 32'h0;
    id_inDelaySlot = 1'b0;
    exc_syscall    = 1'b0;
    exc_illegal    = 1'b0;
    exc_eret       = 1'b0;
    bus.cp0_we     = 1'b0;
    bus.cp0_addr   = 5'd0;
    bus.cp0_wdata  = 32'h0;
  endtask

  // Advance past one rising edge, then park inputs idle at the falling edge.
  task automatic next();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic rdchk(input string tag, input logic [4:0] addr, input logic [31:0] expected);
    bus.cp0_addr = addr;
    #1;
    check(tag, bus.cp0_rdata, expected);
  endtask

  task automatic redirect_chk(input string tag, input logic exp_ctrl, input logic [31:0] exp_target);
    #1;
    check({tag, "_ctrl"}, {31'd0, epc_ctrl}, {31'd0, exp_ctrl});
    check({tag, "_flush"}, {31'd0, flush_if_id}, {31'd0, exp_ctrl});
    check({tag, "_target"}, jumpAddressExcept, exp_target);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] pc);
    id_valid      = 1'b1;
    id_pc         = pc;
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = data;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    ext_int      = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);

    // Reset state
    redirect_chk("reset", 1'b0, 32'h0000_0008);
    check("reset_in_handler", {31'd0, in_handler}, 32'd0);
    rdchk("reset_status", 5'd12, 32'h0000_0001);
    rdchk("reset_cause", 5'd13, 32'h0000_0000);
    rdchk("reset_epc", 5'd14, 32'h0000_0000);
    rdchk("unimpl_read", 5'd5, 32'h0000_0000);
    rst = 1'b0;
    next();

    // MTC0 masking on Status
    mtc0(5'd12, 32'hFFFF_FFFC, 32'h10);
    next();
    rdchk("status_mask0", 5'd12, 32'h0000_0000);
    mtc0(5'd12, 32'hFFFF_FFFD, 32'h14);
    next();
    rdchk("status_mask1", 5'd12, 32'h0000_0001);

    // SYSCALL at 0x40
    id_valid = 1'b1; id_pc = 32'h40; exc_syscall = 1'b1;
    redirect_chk("sys", 1'b1, 32'h0000_0008);
    next();
    rdchk("sys_epc", 5'd14, 32'h0000_0044);
    rdchk("sys_cause", 5'd13, 32'h0000_0020);
    rdchk("sys_status", 5'd12, 32'h0000_0003);
    check("sys_in_handler", {31'd0, in_handler}, 32'd1);

    // ERET back to 0x44
    id_valid = 1'b1; id_pc = 32'h08; exc_eret = 1'b1;
    redirect_chk("eret1", 1'b1, 32'h0000_0044);
    next();
    check("eret1_in_handler", {31'd0, in_handler}, 32'd0);
    rdchk("eret1_status", 5'd12, 32'h0000_0001);

    // Illegal in delay slot, then nested exceptions while EXL=1
    id_valid = 1'b1; id_pc = 32'h104; id_inDelaySlot = 1'b1; exc_illegal = 1'b1;
    exc_syscall = 1'b1;
    redirect_chk("ill_ds", 1'b1, 32'h0000_0008);
    next();
    rdchk("ill_ds_epc", 5'd14, 32'h0000_0100);
    rdchk("ill_ds_cause", 5'd13, 32'h8000_0028);
    id_valid = 1'b1; id_pc = 32'h200; exc_illegal = 1'b1;
    redirect_chk("ill_nested", 1'b1, 32'h0000_0008);
    next();
    rdchk("ill_nested_epc", 5'd14, 32'h0000_0100);
    id_valid = 1'b1; id_pc = 32'h300; exc_syscall = 1'b1;
    next();
    rdchk("sys_nested_epc", 5'd14, 32'h0000_0100);
    rdchk("sys_nested_cause", 5'd13, 32'h8000_0020);
    // ERET outranks an illegal flag in the same instruction
    id_valid = 1'b1; id_pc = 32'h0C; exc_eret = 1'b1; exc_illegal = 1'b1;
    redirect_chk("eret2", 1'b1, 32'h0000_0100);
    next();
    check("eret2_in_handler", {31'd0, in_handler}, 32'd0);

    // Interrupt with IE=1
    ext_int = 1'b1;
    next();
    ext_int = 1'b0;
    rdchk("int_pending", 5'd13, 32'h8000_0420);
    id_valid = 1'b1; id_pc = 32'h20;
    redirect_chk("int", 1'b1, 32'h0000_0008);
    next();
    rdchk("int_epc", 5'd14, 32'h0000_0020);
    rdchk("int_cause", 5'd13, 32'h0000_0000);
    id_valid = 1'b1; exc_eret = 1'b1;
    redirect_chk("eret3", 1'b1, 32'h0000_0020);
    next();

    // Interrupt with IE=0 stays pending until IE is set
    mtc0(5'd12, 32'h0000_0000, 32'h5C);
    next();
    ext_int = 1'b1;
    next();
    ext_int = 1'b0;
    rdchk("int_masked_pending", 5'd13, 32'h0000_0400);
    id_valid = 1'b1; id_pc = 32'h60;
    redirect_chk("int_masked", 1'b0, 32'h0000_0008);
    next();
    rdchk("int_masked_hold", 5'd13, 32'h0000_0400);
    mtc0(5'd12, 32'h0000_0001, 32'h64);
    redirect_chk("mtc0_ie", 1'b0, 32'h0000_0008);
    rdchk("mfc0_old", 5'd12, 32'h0000_0000);
    bus.cp0_addr = 5'd12;
    next();
    rdchk("mtc0_ie_status", 5'd12, 32'h0000_0001);
    id_valid = 1'b1; id_pc = 32'h68;
    redirect_chk("int_unmasked", 1'b1, 32'h0000_0008);
    next();
    rdchk("int_unmasked_epc", 5'd14, 32'h0000_0068);
    rdchk("int_unmasked_cause", 5'd13, 32'h0000_0000);
    id_valid = 1'b1; exc_eret = 1'b1;
    next();

    // SYSCALL + interrupt edge + MTC0 EPC in the same cycle
    id_valid = 1'b1; id_pc = 32'h80; exc_syscall = 1'b1; ext_int = 1'b1;
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_0999;
    redirect_chk("combo", 1'b1, 32'h0000_0008);
    next();
    ext_int = 1'b0;
    rdchk("combo_epc", 5'd14, 32'h0000_0084);
    rdchk("combo_cause", 5'd13, 32'h0000_0420);
    id_valid = 1'b1; id_pc = 32'h0C; exc_eret = 1'b1;
    redirect_chk("eret4", 1'b1, 32'h0000_0084);
    next();
    id_valid = 1'b1; id_pc = 32'h90;
    redirect_chk("combo_int", 1'b1, 32'h0000_0008);
    next();
    rdchk("combo_int_epc", 5'd14, 32'h0000_0090);
    rdchk("combo_int_cause", 5'd13, 32'h0000_0000);
    id_valid = 1'b1; exc_eret = 1'b1;
    next();

    // Stall gates events
    stall = 1'b1; id_valid = 1'b1; id_pc = 32'hA0; exc_syscall = 1'b1;
    redirect_chk("stall", 1'b0, 32'h0000_0008);
    next();
    check("stall_in_handler", {31'd0, in_handler}, 32'd0);
    rdchk("stall_epc", 5'd14, 32'h0000_0090);
    rdchk("stall_cause", 5'd13, 32'h0000_0000);

    // Delay-slot EPC wrap, then reset mid-handler with a pending interrupt
    id_valid = 1'b1; id_pc = 32'h0; id_inDelaySlot = 1'b1; exc_illegal = 1'b1;
    next();
    rdchk("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    ext_int = 1'b1;
    next();
    ext_int = 1'b0;
    rdchk("wrap_cause", 5'd13, 32'h8000_0428);
    check("wrap_in_handler", {31'd0, in_handler}, 32'd1);
    rst = 1'b1;
    next();
    rst = 1'b0;
    rdchk("rst2_status", 5'd12, 32'h0000_0001);
    rdchk("rst2_epc", 5'd14, 32'h0000_0000);
    rdchk("rst2_cause", 5'd13, 32'h0000_0000);
    check("rst2_in_handler", {31'd0, in_handler}, 32'd0);
    redirect_chk("rst2", 1'b0, 32'h0000_0008);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
